// File: rtl/syst_seq_ctrl_if.sv
// Bundled command, memory and array signals of the systolic-array sequencer.
// master: the sequencer's view; slave: command source, memory and array view.
interface syst_seq_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic          start_i;
  logic [AW-1:0] w_base_i;
  logic [AW-1:0] x_base_i;
  logic [AW-1:0] r_base_i;
  logic [AW-1:0] x_cnt_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          mem_rd_o;
  logic [AW-1:0] mem_radr_o;
  logic [DW-1:0] mem_rdat_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_wadr_o;
  logic [DW-1:0] mem_wdat_o;
  logic [DW-1:0] arr_data_o;
  logic          arr_valid_o;
  logic [3:0]    arr_valid_raw_o;
  logic          arr_ready_o;
  logic          arr_valid_i;
  logic [DW-1:0] arr_data_i;

  modport master (
    input  start_i, w_base_i, x_base_i, r_base_i, x_cnt_i,
    input  mem_rdat_i, arr_valid_i, arr_data_i,
    output busy_o, done_o, err_o,
    output mem_rd_o, mem_radr_o, mem_we_o, mem_wadr_o, mem_wdat_o,
    output arr_data_o, arr_valid_o, arr_valid_raw_o, arr_ready_o
  );

  modport slave (
    output start_i, w_base_i, x_base_i, r_base_i, x_cnt_i,
    output mem_rdat_i, arr_valid_i, arr_data_i,
    input  busy_o, done_o, err_o,
    input  mem_rd_o, mem_radr_o, mem_we_o, mem_wadr_o, mem_wdat_o,
    input  arr_data_o, arr_valid_o, arr_valid_raw_o, arr_ready_o
  );
endinterface

// File: rtl/syst_seq_ctrl.sv
// Systolic-array job sequencer: loads 4 weight rows, streams activations, writes results back.
// Optional DRAIN watchdog enabled by defining SYST_SEQ_TIMEOUT_EN.
module syst_seq_ctrl #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  syst_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [AW:0]   rd_idx_r, rd_idx_s;
  logic [AW-1:0] w_base_r, x_base_r, r_base_r, x_cnt_r;
  logic [AW-1:0] res_cnt_r;
  logic [3:0]    wv_r;
  logic          xv_r;
  logic          done_r;
  logic          err_r;
  logic          start_ok_s;
  logic          ready_s;
  logic          accept_s;
  logic          res_full_s;
  logic          x_last_s;
  logic          timeout_s;

  assign start_ok_s = (state_r == ST_IDLE) && bus.start_i;
  // Result counter saturates at the job count: once full, the array is refused.
  assign ready_s    = ((state_r == ST_LOAD_X) || (state_r == ST_DRAIN)) && (res_cnt_r != x_cnt_r);
  assign accept_s   = ready_s && bus.arr_valid_i;
  assign res_full_s = ((res_cnt_r + AW'(accept_s)) == x_cnt_r);
  assign x_last_s   = ((rd_idx_r + (AW+1)'(1)) == {1'b0, x_cnt_r});

`ifdef SYST_SEQ_TIMEOUT_EN
  logic [15:0] wdog_r;

  // Watchdog: counts DRAIN cycles without an accepted result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_r <= 16'd0;
    end else if ((state_r != ST_DRAIN) || accept_s) begin
      wdog_r <= 16'd0;
    end else begin
      wdog_r <= wdog_r + 16'd1;
    end
  end

  assign timeout_s = (state_r == ST_DRAIN) && !accept_s && (wdog_r == 16'hFFFF);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and read-index logic.
  always_comb begin
    state_s  = state_r;
    rd_idx_s = rd_idx_r;
    case (state_r)
      ST_IDLE: begin
        rd_idx_s = {(AW+1){1'b0}};
        if (bus.start_i) begin
          if (bus.x_cnt_i == {AW{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD_W;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        // Hand over straight to activation reads so the read stream has no bubble.
        if (rd_idx_r == (AW+1)'(3)) begin
          state_s  = ST_LOAD_X;
          rd_idx_s = {(AW+1){1'b0}};
        end else begin
          rd_idx_s = rd_idx_r + (AW+1)'(1);
        end
      end
      ST_LOAD_X: begin
        if (x_last_s) begin
          state_s  = ST_DRAIN;
          rd_idx_s = {(AW+1){1'b0}};
        end else begin
          rd_idx_s = rd_idx_r + (AW+1)'(1);
        end
      end
      ST_DRAIN: begin
        if (timeout_s || res_full_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s  = ST_IDLE;
        rd_idx_s = {(AW+1){1'b0}};
      end
    endcase
  end

  // State, job parameters, counters, strobe pipeline and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      rd_idx_r  <= {(AW+1){1'b0}};
      w_base_r  <= {AW{1'b0}};
      x_base_r  <= {AW{1'b0}};
      r_base_r  <= {AW{1'b0}};
      x_cnt_r   <= {AW{1'b0}};
      res_cnt_r <= {AW{1'b0}};
      wv_r      <= 4'b0000;
      xv_r      <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      rd_idx_r <= rd_idx_s;
      if (start_ok_s && (bus.x_cnt_i != {AW{1'b0}})) begin
        w_base_r <= bus.w_base_i;
        x_base_r <= bus.x_base_i;
        r_base_r <= bus.r_base_i;
        x_cnt_r  <= bus.x_cnt_i;
      end
      if (start_ok_s) begin
        res_cnt_r <= {AW{1'b0}};
      end else if (accept_s) begin
        res_cnt_r <= res_cnt_r + AW'(1);
      end
      // Strobes trail their read by one cycle to line up with the returned data.
      wv_r   <= (state_r == ST_LOAD_W) ? (4'b0001 << rd_idx_r[1:0]) : 4'b0000;
      xv_r   <= (state_r == ST_LOAD_X);
      done_r <= (state_r == ST_DONE);
      if (start_ok_s) begin
        err_r <= (bus.x_cnt_i == {AW{1'b0}});
      end else if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Output decode; every strobe, address and data bus idles at zero.
  always_comb begin
    bus.busy_o          = (state_r != ST_IDLE);
    bus.done_o          = done_r;
    bus.err_o           = err_r;
    bus.arr_ready_o     = ready_s;
    bus.arr_valid_raw_o = wv_r;
    bus.arr_valid_o     = xv_r;
    bus.mem_rd_o        = 1'b0;
    bus.mem_radr_o      = {AW{1'b0}};
    bus.mem_we_o        = 1'b0;
    bus.mem_wadr_o      = {AW{1'b0}};
    bus.mem_wdat_o      = {DW{1'b0}};
    bus.arr_data_o      = {DW{1'b0}};
    if (state_r == ST_LOAD_W) begin
      bus.mem_rd_o   = 1'b1;
      bus.mem_radr_o = w_base_r + rd_idx_r[AW-1:0];
    end else if (state_r == ST_LOAD_X) begin
      bus.mem_rd_o   = 1'b1;
      bus.mem_radr_o = x_base_r + rd_idx_r[AW-1:0];
    end else begin
      bus.mem_rd_o   = 1'b0;
      bus.mem_radr_o = {AW{1'b0}};
    end
    if (accept_s) begin
      bus.mem_we_o   = 1'b1;
      bus.mem_wadr_o = r_base_r + res_cnt_r;
      bus.mem_wdat_o = bus.arr_data_i;
    end else begin
      bus.mem_we_o   = 1'b0;
      bus.mem_wadr_o = {AW{1'b0}};
      bus.mem_wdat_o = {DW{1'b0}};
    end
    if ((wv_r != 4'b0000) || xv_r) begin
      bus.arr_data_o = bus.mem_rdat_i;
    end else begin
      bus.arr_data_o = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_syst_seq_ctrl.sv
// Directed bench for syst_seq_ctrl: per-cycle vector table for a full job plus corner sequences.
module tb_syst_seq_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  syst_seq_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  syst_seq_ctrl #(.DW(DW), .AW(AW)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  // Scratch memory: synchronous read, preloaded while reset is held.
  logic [DW-1:0] mem [0:255];

  function automatic logic [DW-1:0] init_word(input int a);
    case (a)
      16'h10:  return 32'h11;
      16'h11:  return 32'h22;
      16'h12:  return 32'h33;
      16'h13:  return 32'h44;
      16'h20:  return 32'hA1;
      16'h21:  return 32'hA2;
      default: return 32'(a) ^ 32'h5A00;
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      bus.mem_rdat_i <= '0;
    end else begin
      bus.mem_rdat_i <= bus.mem_rd_o ? mem[bus.mem_radr_o] : 32'h0;
      if (bus.mem_we_o) mem[bus.mem_wadr_o] <= bus.mem_wdat_o;
    end
  end

  // Monitor: read-address log and running write/done counts.
  logic [7:0] rd_log [$];
  int we_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk_i) begin
    if (bus.mem_rd_o) rd_log.push_back(bus.mem_radr_o);
    if (bus.mem_we_o) we_cnt <= we_cnt + 1;
    if (bus.done_o) done_cnt <= done_cnt + 1;
  end

  logic [90:0] obs_s;
  assign obs_s = {bus.busy_o, bus.mem_rd_o, bus.mem_radr_o, bus.arr_valid_raw_o,
                  bus.arr_valid_o, bus.arr_data_o, bus.arr_ready_o, bus.mem_we_o,
                  bus.mem_wadr_o, bus.mem_wdat_o, bus.done_o, bus.err_o};

  typedef struct {
    logic        start;
    logic        avi;
    logic [31:0] adi;
    logic        busy;
    logic        rd;
    logic [7:0]  radr;
    logic [3:0]  raw;
    logic        av;
    logic [31:0] ad;
    logic        rdy;
    logic        we;
    logic [7:0]  wadr;
    logic [31:0] wdat;
    logic        done;
    logic        err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl [11];
  logic [7:0] exp_rd [8];
  int rd0, we0, dn0, cyc;

  initial begin
    //         st  avi adi        busy rd radr   raw     av ad        rdy we wadr   wdat       dn er
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h00, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 8'h10, 4'b0000, 1'b0, 32'h00, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 8'h11, 4'b0001, 1'b0, 32'h11, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 8'h12, 4'b0010, 1'b0, 32'h22, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 8'h13, 4'b0100, 1'b0, 32'h33, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 8'h20, 4'b1000, 1'b0, 32'h44, 1'b1, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'hB1, 1'b1, 1'b1, 8'h21, 4'b0000, 1'b1, 32'hA1, 1'b1, 1'b1, 8'h30, 32'hB1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'hB2, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 32'hA2, 1'b1, 1'b1, 8'h31, 32'hB2, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h00, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h00, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h00, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0};
    exp_rd = '{8'h40, 8'h41, 8'h42, 8'h43, 8'hFE, 8'hFF, 8'h00, 8'h01};

    rst_i = 1'b1;
    bus.start_i = 1'b0;
    bus.w_base_i = 8'h00;
    bus.x_base_i = 8'h00;
    bus.r_base_i = 8'h00;
    bus.x_cnt_i = 8'h00;
    bus.arr_valid_i = 1'b0;
    bus.arr_data_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset held outputs", 128'(obs_s), 128'h0);
    rst_i = 1'b0;
    step();
    step();
    check("idle after release", 128'(obs_s), 128'h0);

    // Full job, x_cnt=2: weights 0x11..0x44, activations 0xA1/0xA2, results 0xB1/0xB2.
    bus.w_base_i = 8'h10;
    bus.x_base_i = 8'h20;
    bus.r_base_i = 8'h30;
    bus.x_cnt_i  = 8'd2;
    for (int i = 0; i < 11; i++) begin
      bus.start_i     = tbl[i].start;
      bus.arr_valid_i = tbl[i].avi;
      bus.arr_data_i  = tbl[i].adi;
      #1;
      check($sformatf("job row%0d", i), 128'(obs_s),
            128'({tbl[i].busy, tbl[i].rd, tbl[i].radr, tbl[i].raw, tbl[i].av, tbl[i].ad,
                  tbl[i].rdy, tbl[i].we, tbl[i].wadr, tbl[i].wdat, tbl[i].done, tbl[i].err}));
      step();
    end
    check("result word 0 in mem", 128'(mem[8'h30]), 128'hB1);
    check("result word 1 in mem", 128'(mem[8'h31]), 128'hB2);

    // Zero count: error completion, no memory traffic.
    rd0 = rd_log.size();
    we0 = we_cnt;
    bus.x_cnt_i = 8'd0;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    check("zero cnt c1 busy/done", 128'({bus.busy_o, bus.done_o}), 128'b10);
    step();
    check("zero cnt c2 busy/done/err", 128'({bus.busy_o, bus.done_o, bus.err_o}), 128'b011);
    step();
    check("zero cnt err held", 128'({bus.done_o, bus.err_o}), 128'b01);
    check("zero cnt mem traffic", 128'((rd_log.size() - rd0) + (we_cnt - we0)), 128'd0);

    // Address wrap, ignored mid-job start, fifth result refused.
    rd0 = rd_log.size();
    we0 = we_cnt;
    dn0 = done_cnt;
    bus.w_base_i = 8'h40;
    bus.x_base_i = 8'hFE;
    bus.r_base_i = 8'hFF;
    bus.x_cnt_i  = 8'd4;
    for (int c = 0; c < 15; c++) begin
      bus.start_i     = (c == 0) || (c == 3);
      bus.arr_valid_i = (c >= 5) && (c <= 9);
      bus.arr_data_i  = bus.arr_valid_i ? (32'hC0 + 32'(c) - 32'd5) : 32'h0;
      #1;
      if (c == 9) check("fifth result ready/we", 128'({bus.arr_ready_o, bus.mem_we_o}), 128'b00);
      if (c == 11) check("wrap job done/err", 128'({bus.done_o, bus.err_o}), 128'b10);
      step();
    end
    bus.start_i = 1'b0;
    bus.arr_valid_i = 1'b0;
    check("wrap read count", 128'(rd_log.size() - rd0), 128'd8);
    for (int j = 0; j < 8; j++) begin
      if (rd0 + j < rd_log.size())
        check($sformatf("wrap read addr %0d", j), 128'(rd_log[rd0 + j]), 128'(exp_rd[j]));
    end
    check("wrap write count", 128'(we_cnt - we0), 128'd4);
    check("wrap done count", 128'(done_cnt - dn0), 128'd1);
    check("wrap result @FF", 128'(mem[8'hFF]), 128'hC0);
    check("wrap result @00", 128'(mem[8'h00]), 128'hC1);
    check("wrap result @01", 128'(mem[8'h01]), 128'hC2);
    check("wrap result @02", 128'(mem[8'h02]), 128'hC3);

`ifdef SYST_SEQ_TIMEOUT_EN
    // Silent array: watchdog must end the job with an error.
    bus.x_base_i = 8'h20;
    bus.r_base_i = 8'h30;
    bus.x_cnt_i  = 8'd1;
    bus.start_i  = 1'b1;
    cyc = 0;
    step();
    bus.start_i = 1'b0;
    cyc = 1;
    while (!bus.done_o && cyc < 70000) begin
      step();
      cyc++;
    end
    check("timeout done cycle", 128'(cyc), 128'd65543);
    check("timeout done/err", 128'({bus.done_o, bus.err_o}), 128'b11);
    step();
`endif

    // Reset during LOAD_X: immediate quiet outputs, no completion afterwards.
    dn0 = done_cnt;
    bus.w_base_i = 8'h10;
    bus.x_base_i = 8'h50;
    bus.r_base_i = 8'h60;
    bus.x_cnt_i  = 8'd3;
    bus.start_i  = 1'b1;
    step();
    bus.start_i = 1'b0;
    repeat (5) step();
    check("load_x reading before reset", 128'({bus.mem_rd_o, bus.mem_radr_o}), 128'({1'b1, 8'h51}));
    rst_i = 1'b1;
    #1;
    check("reset mid-job outputs", 128'(obs_s), 128'h0);
    step();
    rst_i = 1'b0;
    repeat (15) step();
    check("no done after abort", 128'(done_cnt - dn0), 128'd0);
    check("idle after abort", 128'(obs_s), 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
